signed_bcd_display: RTL and testbench
=====================================

# signed_bcd_display

Parametrised signed-binary to multi-digit seven-segment driver. Accepts a WIDTH-bit two's-complement value on a start strobe and converts its magnitude to BCD with a sequential double-dabble engine, one bit per clock. It then drives DIGITS active-low magnitude digits plus a separate sign digit. It is the generalised successor of the team's 4-bit fixed-table signed display decoder and sits between datapath result registers and the board's seven-segment pins.

## Interface
- WIDTH, default 8: input value width, two's complement; legal range 2..16.
- DIGITS, default 3: magnitude digit count; must satisfy 10^DIGITS > 2^(WIDTH-1). Elaboration fails otherwise.
- BLANK_LZ, default 1: 1 blanks leading zero digits; digit 0 is never blanked.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request a conversion of value; sampled only in IDLE.
- value  in  WIDTH  signed operand, captured on the accepted start edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when the new display outputs take effect.
- seg_digits  out  7*DIGITS  digit k at bits [7k+6:7k], k=0 least significant; each field is {a,b,c,d,e,f,g} with a at the MSB; 0 = segment lit.
- seg_sign  out  7  sign digit, same encoding.

## Operation
- Segment codes: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank=1111111.
- Sign digit: minus=1111110 (g only) when value is negative; blank otherwise. Zero is non-negative.
- Magnitude: unsigned WIDTH-bit |value|. The most negative value, -2^(WIDTH-1), yields magnitude 2^(WIDTH-1) without overflow.
- FSM:
  - IDLE: on start=1, capture sign and magnitude, clear the BCD register, load bit counter = WIDTH, go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, mag} left by one bit and decrement the counter. When the counter reaches 1 after the shift, go to UPD.
  - UPD: encode the BCD register through the segment table with leading-zero blanking, register seg_digits and seg_sign, pulse done, return to IDLE.
- start while busy or in UPD is ignored; it is not queued.
- value changes after capture have no effect on the running conversion.
- Outputs hold the previous result for the whole conversion, so the display does not flicker.
- Leading-zero blanking: scanning from digit DIGITS-1 down to digit 1, each zero digit is blanked until the first nonzero digit is reached.

## Timing
- Reset values: seg_digits all 1 (every digit blank), seg_sign=1111111, busy=0, done=0, FSM in IDLE.
- Latency: start is sampled at edge T. busy rises after edge T. CONV occupies edges T+1..T+WIDTH. At edge T+WIDTH+1, the outputs update, done=1 and busy=0.
- done is high for exactly one cycle. The earliest next accepted start is at edge T+WIDTH+2.
- Throughput: one conversion per WIDTH+2 cycles.
- Reset asserted mid-conversion: all state and outputs return to their reset values immediately. No done pulse is produced for the aborted conversion.

## Structure
- Package seg7_pkg holds:
  - constants SEG_BLANK and SEG_MINUS;
  - the ten digit codes as a localparam array;
  - the FSM state typedef (IDLE, CONV, UPD).
- Sub-module seg7_encode: combinational 4-bit BCD plus blank input to 7-bit active-low code. It is instantiated DIGITS times for the magnitude digits.
- The BCD register is 4*DIGITS bits. The bit counter is clog2(WIDTH+1) bits.

## Test plan
- Reset, then WIDTH=8, DIGITS=3, value=0, start -> at edge T+9: seg_digits={1111111,1111111,0000001}, seg_sign=1111111, done pulses one cycle.
- value=8'h80 (-128) -> digits 1,2,8 = {1001111,0010010,0000000}, seg_sign=1111110.
- value=8'h7F -> 127 = {1001111,0010010,0001111}, sign blank. value=8'hFF -> {blank,blank,1001111}, sign minus.
- Assert start on every cycle during a conversion -> only the first start is accepted; exactly one done per WIDTH+2 cycles; outputs unchanged until done.
- Assert rst_n low at edge T+4 of a conversion -> outputs blank and busy=0 immediately; no done pulse follows.
- BLANK_LZ=0, value=5 -> {0000001,0000001,0100100}. WIDTH=16, DIGITS=5, value=16'h8000 -> 32768 with sign minus, done at edge T+17.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment codes and FSM state type for signed_bcd_display
// Codes are {a,b,c,d,e,f,g}, a at the MSB, active-low (0 = segment lit).
package seg7_pkg;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [6:0] SEG_CODE [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    typedef enum logic [1:0] {IDLE, CONV, UPD} state_t;
endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: one BCD digit to an active-low seven-segment code
// Ports: bcd (4-bit digit), blank (force all segments off), seg (7-bit {a..g}).
// Non-decimal nibbles render blank rather than garbage.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);
    assign seg = (blank || bcd > 4'd9) ? SEG_BLANK : SEG_CODE[bcd];
endmodule

// File: rtl/signed_bcd_display.sv
// signed_bcd_display: signed binary to multi-digit seven-segment driver via serial double-dabble
// Ports: clk, rst_n (async, active-low), start/value (conversion request),
//        busy (conversion running), done (one-cycle pulse as new outputs land),
//        seg_digits (DIGITS active-low digits, digit k at [7k+6:7k]), seg_sign (minus or blank).
module signed_bcd_display
    import seg7_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [7*DIGITS-1:0]   seg_digits,
    output logic [6:0]            seg_sign
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    // The digit count must hold the largest magnitude, 2^(WIDTH-1).
    if (WIDTH < 2 || WIDTH > 16 || (64'd10 ** DIGITS) <= (64'd1 << (WIDTH - 1))) begin : g_bad_params
        $error("signed_bcd_display: illegal WIDTH/DIGITS combination");
    end

    state_t               state, state_nx;
    logic                 sign;
    logic [WIDTH-1:0]     mag, mag_nx;
    logic [BW-1:0]        bcd, adj, bcd_nx;
    logic [CW-1:0]        cnt;
    logic [7*DIGITS-1:0]  enc;
    logic [DIGITS:1]      lz;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        if (state == IDLE && start)               state_nx = CONV;
        else if (state == CONV && cnt == CW'(1))  state_nx = UPD;
        else if (state == UPD)                    state_nx = IDLE;
    end

    assign busy = state != IDLE;

    // Double-dabble step: correct every nibble that would overflow past 9 once doubled, then shift.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            if (bcd[4*i+:4] > 4'd4) adj[4*i+:4] = bcd[4*i+:4] + 4'd3;
        {bcd_nx, mag_nx} = {adj[BW-2:0], mag, 1'b0};
    end

    // The negate is WIDTH bits unsigned, so the most negative input maps to 2^(WIDTH-1) exactly.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sign       <= 1'b0;
            mag        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            seg_digits <= '1;
            seg_sign   <= SEG_BLANK;
        end else begin
            done <= state == UPD;
            if (state == IDLE && start) begin
                sign <= value[WIDTH-1];
                mag  <= value[WIDTH-1] ? -value : value;
                bcd  <= '0;
                cnt  <= CW'(WIDTH);
            end else if (state == CONV) begin
                bcd <= bcd_nx;
                mag <= mag_nx;
                cnt <= cnt - 1'b1;
            end
            if (state == UPD) begin
                seg_digits <= enc;
                seg_sign   <= sign ? SEG_MINUS : SEG_BLANK;
            end
        end

    // lz[k]: digits k..DIGITS-1 are all zero, so digit k is a leading zero.
    assign lz[DIGITS] = 1'b1;
    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        if (k == 0) begin : g_lsd
            seg7_encode u_enc (.bcd(bcd[3:0]), .blank(1'b0), .seg(enc[6:0]));
        end else begin : g_msd
            assign lz[k] = lz[k+1] && bcd[4*k+:4] == 4'd0;
            seg7_encode u_enc (.bcd(bcd[4*k+:4]), .blank(BLANK_LZ != 0 && lz[k]), .seg(enc[7*k+:7]));
        end
    end
endmodule

// File: tb/tb_signed_bcd_display.sv
// tb_signed_bcd_display: self-checking bench for signed_bcd_display in three configurations
module tb_signed_bcd_display;
    localparam int WD [3] = '{8, 8, 16};
    localparam int DG [3] = '{3, 3, 5};
    localparam int BZ [3] = '{1, 0, 1};
    localparam logic [6:0] TB_CODE [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] MIN = 7'b1111110;

    logic clk = 1'b0, rst_n = 1'b0;
    logic sa = 1'b0, sb = 1'b0, sc = 1'b0;
    logic [7:0] va = '0, vb = '0;
    logic [15:0] vc = '0;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [20:0] seg_a, seg_b;
    logic [34:0] seg_c;
    logic [6:0] sign_a, sign_b, sign_c;

    int n_cmp = 0, n_err = 0;
    logic [34:0] last_seg [3];
    logic [6:0] last_sign [3];

    always #5 clk = ~clk;

    signed_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(sa), .value(va), .busy(busy_a), .done(done_a),
        .seg_digits(seg_a), .seg_sign(sign_a));
    signed_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(sb), .value(vb), .busy(busy_b), .done(done_b),
        .seg_digits(seg_b), .seg_sign(sign_b));
    signed_bcd_display #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(sc), .value(vc), .busy(busy_c), .done(done_c),
        .seg_digits(seg_c), .seg_sign(sign_c));

    // Reference: decimal digits of |v| by division; leading zeros are the positions above the
    // most significant digit of the magnitude, never position 0.
    function automatic logic [34:0] model(int v, int d, int blz);
        logic [34:0] r = '0;
        int m = v < 0 ? -v : v;
        int p = 1;
        for (int k = 0; k < d; k++) begin
            r[7*k+:7] = (blz != 0 && k > 0 && m < p) ? BLK : TB_CODE[(m / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [34:0] obs_seg(int w);
        return w == 0 ? 35'(seg_a) : w == 1 ? 35'(seg_b) : seg_c;
    endfunction
    function automatic logic [6:0] obs_sign(int w);
        return w == 0 ? sign_a : w == 1 ? sign_b : sign_c;
    endfunction
    function automatic logic obs_busy(int w);
        return w == 0 ? busy_a : w == 1 ? busy_b : busy_c;
    endfunction
    function automatic logic obs_done(int w);
        return w == 0 ? done_a : w == 1 ? done_b : done_c;
    endfunction

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int w, input logic s, input int v);
        case (w)
            0: begin sa = s; va = v[7:0]; end
            1: begin sb = s; vb = v[7:0]; end
            default: begin sc = s; vc = v[15:0]; end
        endcase
    endtask

    // One conversion on DUT w; with hammer, start stays high and value churns throughout.
    task automatic convert(input int w, input int v, input bit hammer);
        logic [34:0] es = model(v, DG[w], BZ[w]);
        logic [6:0] esg = v < 0 ? MIN : BLK;
        set_in(w, 1'b1, v);
        @(posedge clk); #1;
        set_in(w, hammer, int'($urandom));
        chk("busy_rise", 35'(obs_busy(w)), 35'd1);
        chk("done_early", 35'(obs_done(w)), 35'd0);
        for (int i = 1; i <= WD[w]; i++) begin
            @(posedge clk); #1;
            chk("hold_seg", obs_seg(w), last_seg[w]);
            chk("hold_sign", 35'(obs_sign(w)), 35'(last_sign[w]));
            chk("conv_done", 35'(obs_done(w)), 35'd0);
            chk("conv_busy", 35'(obs_busy(w)), 35'd1);
            set_in(w, hammer, int'($urandom));
        end
        @(posedge clk); #1;
        set_in(w, 1'b0, 0);
        chk("done_pulse", 35'(obs_done(w)), 35'd1);
        chk("busy_fall", 35'(obs_busy(w)), 35'd0);
        chk("result_seg", obs_seg(w), es);
        chk("result_sign", 35'(obs_sign(w)), 35'(esg));
        @(posedge clk); #1;
        chk("done_once", 35'(obs_done(w)), 35'd0);
        chk("idle_busy", 35'(obs_busy(w)), 35'd0);
        last_seg[w] = es;
        last_sign[w] = esg;
    endtask

    task automatic check_reset_state;
        for (int w = 0; w < 3; w++) begin
            last_seg[w] = model(0, DG[w], 1) | 35'h7_FFFF_FFFF;
            last_seg[w] = w == 2 ? last_seg[w] : {14'd0, 21'h1F_FFFF};
            last_sign[w] = BLK;
            chk("rst_seg", obs_seg(w), last_seg[w]);
            chk("rst_sign", 35'(obs_sign(w)), 35'(BLK));
            chk("rst_busy", 35'(obs_busy(w)), 35'd0);
            chk("rst_done", 35'(obs_done(w)), 35'd0);
        end
    endtask

    initial begin
        #12;
        check_reset_state();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        convert(0, 0, 1'b0);
        convert(0, -128, 1'b0);
        convert(0, 127, 1'b0);
        convert(0, -1, 1'b0);
        convert(0, 42, 1'b1);
        convert(1, 5, 1'b0);
        convert(1, -7, 1'b0);
        convert(2, -32768, 1'b0);
        convert(2, 32767, 1'b1);
        convert(2, 0, 1'b0);

        for (int n = 0; n < 20; n++)
            for (int w = 0; w < 3; w++)
                convert(w, int'($urandom_range(0, (1 << WD[w]) - 1)) - (1 << (WD[w] - 1)),
                        bit'($urandom_range(0, 1)));

        // Abort a conversion partway: everything returns to reset values at once, no done follows.
        sa = 1'b1; va = 8'h9C;
        @(posedge clk); #1;
        sa = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < WD[0] + 3; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 35'(done_a), 35'd0);
        end
        chk("abort_seg", obs_seg(0), {14'd0, 21'h1F_FFFF});
        convert(0, -99, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
